ram_mover: RTL and testbench

RAM_MOVER -- requirements
Module: ram_mover

---
 rtl/ram_mover.sv | 206 ++++++++++++++++++++
 tb/tb_ram_mover.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_mover.sv
// ---------------------------------------------------------------------------
// RamMover: moves blocks of words inside a single-port synchronous RAM.
//
// A copy reads a word (RD), waits one cycle for the read data (WT), then
// writes it (WR). This costs 3 cycles per word, in strictly ascending address
// order, with no correction when the ranges overlap. A fill writes a latched
// constant on every cycle, so it costs 1 cycle per word. Both address
// pointers wrap modulo 2^ADDR_W. done pulses for one cycle in FIN.
//
// Optional feature: define RAM_MOVER_FILL_EN to enable fill mode. Without
// it, fill and fill_data are ignored and every transfer is a copy.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   start      : one-cycle request pulse, sampled only in IDLE
//   src_addr   : first source word address
//   dst_addr   : first destination word address
//   len        : word count, 0 .. 2^ADDR_W
//   fill       : fill-mode select (only with RAM_MOVER_FILL_EN)
//   fill_data  : constant written in fill mode
//   abort      : finish the current word, then stop
//   M_cen      : RAM chip enable
//   M_wen      : RAM write enable (1 = write, 0 = read)
//   M_addr     : RAM word address
//   M_din      : RAM write data
//   M_dout     : RAM read data, valid the cycle after a read access
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse at the end of a transfer
//   aborted    : pulses with done when abort cut the transfer short
// ---------------------------------------------------------------------------
module ram_mover #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              abort,
  output logic              M_cen,
  output logic              M_wen,
  output logic [ADDR_W-1:0] M_addr,
  output logic [DATA_W-1:0] M_din,
  input  logic [DATA_W-1:0] M_dout,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WT   = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_srcPtr;
  logic [ADDR_W-1:0] r_dstPtr;
  logic [ADDR_W:0]   r_count;
  logic              r_fillMode;
  logic              r_abortReq;
  logic              r_zeroWait;

  logic              w_fillSel;
  logic              w_abortHit;
  logic              w_lastWord;

`ifdef RAM_MOVER_FILL_EN
  logic [DATA_W-1:0] r_fillData;
  assign w_fillSel = fill;
`else
  logic w_unusedFill;
  assign w_fillSel    = 1'b0;
  assign w_unusedFill = fill ^ (^fill_data);
`endif

  // An abort seen in RD or WT is remembered in r_abortReq. An abort seen
  // in WR itself counts at once. Either way, the word now being written
  // still completes.
  assign w_abortHit = abort | r_abortReq;
  assign w_lastWord = (r_count == (ADDR_W+1)'(1));

  // Single-process FSM. All RAM controls and status flags are registered.
  // They are set on the edge that enters the state they belong to, so they
  // line up exactly with r_state. M_din also serves as the copy data
  // buffer: it captures M_dout at the end of WT and is held through WR.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_srcPtr   <= '0;
      r_dstPtr   <= '0;
      r_count    <= '0;
      r_fillMode <= 1'b0;
      r_abortReq <= 1'b0;
      r_zeroWait <= 1'b0;
`ifdef RAM_MOVER_FILL_EN
      r_fillData <= '0;
`endif
      M_cen      <= 1'b0;
      M_wen      <= 1'b0;
      M_addr     <= '0;
      M_din      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      M_cen   <= 1'b0;
      M_wen   <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      busy    <= 1'b1;
      case (r_state)
        IDLE: begin
          if (!start) begin
            busy <= 1'b0;
          end else if (len == '0) begin
            // An empty transfer spends one quiet cycle in FIN before
            // pulsing done. This keeps its done pulse two cycles after
            // start.
            r_state    <= FIN;
            r_zeroWait <= 1'b1;
          end else begin
            r_srcPtr   <= src_addr;
            r_dstPtr   <= dst_addr;
            r_count    <= len;
            r_fillMode <= w_fillSel;
            r_abortReq <= 1'b0;
`ifdef RAM_MOVER_FILL_EN
            r_fillData <= fill_data;
`endif
            M_cen <= 1'b1;
            if (w_fillSel) begin
              r_state <= WR;
              M_wen   <= 1'b1;
              M_addr  <= dst_addr;
`ifdef RAM_MOVER_FILL_EN
              M_din   <= fill_data;
`endif
            end else begin
              r_state <= RD;
              M_addr  <= src_addr;
            end
          end
        end
        RD: begin
          r_abortReq <= r_abortReq | abort;
          r_state    <= WT;
        end
        WT: begin
          r_abortReq <= r_abortReq | abort;
          r_state    <= WR;
          M_cen      <= 1'b1;
          M_wen      <= 1'b1;
          M_addr     <= r_dstPtr;
          M_din      <= M_dout;
        end
        WR: begin
          r_srcPtr <= r_srcPtr + ADDR_W'(1);
          r_dstPtr <= r_dstPtr + ADDR_W'(1);
          r_count  <= r_count - (ADDR_W+1)'(1);
          if (w_lastWord || w_abortHit) begin
            // aborted reports only a cut-short transfer. An abort that
            // arrives on the final word changes nothing.
            r_state <= FIN;
            done    <= 1'b1;
            aborted <= w_abortHit & ~w_lastWord;
          end else if (r_fillMode) begin
            r_state <= WR;
            M_cen   <= 1'b1;
            M_wen   <= 1'b1;
            M_addr  <= r_dstPtr + ADDR_W'(1);
`ifdef RAM_MOVER_FILL_EN
            M_din   <= r_fillData;
`endif
          end else begin
            r_state <= RD;
            M_cen   <= 1'b1;
            M_addr  <= r_srcPtr + ADDR_W'(1);
          end
        end
        FIN: begin
          if (r_zeroWait) begin
            r_zeroWait <= 1'b0;
            done       <= 1'b1;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_zeroWait <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_mover.sv
// ---------------------------------------------------------------------------
// Testbench for ram_mover. It models a 32-word synchronous RAM.
// It runs a table of directed transfers, a reset-in-the-middle sequence,
// and randomized transfers. Expected memory contents come from a
// word-by-word reference model that works on a shadow copy of the RAM.
// ---------------------------------------------------------------------------
module tb_ram_mover;

`ifdef RAM_MOVER_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  src_addr;
  logic [4:0]  dst_addr;
  logic [5:0]  len;
  logic        fill;
  logic [31:0] fill_data;
  logic        abort;
  logic        M_cen;
  logic        M_wen;
  logic [4:0]  M_addr;
  logic [31:0] M_din;
  logic [31:0] M_dout;
  logic        busy;
  logic        done;
  logic        aborted;

  logic [31:0] mem    [32];
  logic [31:0] refMem [32];
  logic [4:0]  readLog[$];
  logic [4:0]  writeLog[$];
  bit          loadMem;
  bit          clearLog;

  int checks;
  int errors;

  ram_mover #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .fill(fill), .fill_data(fill_data),
    .abort(abort), .M_cen(M_cen), .M_wen(M_wen), .M_addr(M_addr),
    .M_din(M_din), .M_dout(M_dout), .busy(busy), .done(done),
    .aborted(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int i);
    return (i >= 1 && i <= 4) ? 32'(i) : (32'hC0DE_0000 | 32'(i));
  endfunction

  // Synchronous RAM. It also logs every access, so the bench can check
  // the read and write order.
  always @(posedge clk) begin
    if (loadMem) begin
      for (int i = 0; i < 32; i++) mem[i] <= initWord(i);
    end
    if (clearLog) begin
      readLog.delete();
      writeLog.delete();
    end
    if (M_cen === 1'b1) begin
      if (M_wen === 1'b1) begin
        mem[M_addr] <= M_din;
        writeLog.push_back(M_addr);
      end else begin
        M_dout <= mem[M_addr];
        readLog.push_back(M_addr);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic checkMem(input string name);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("%s.mem[%0d]", name, i), mem[i], refMem[i]);
  endtask

  // Reference model: the transfer moves words one at a time in ascending
  // order. Each word is read after the previous word is written.
  task automatic modelMove(input logic [4:0] s, input logic [4:0] d,
                           input int n, input bit effFill,
                           input logic [31:0] fd);
    for (int i = 0; i < n; i++)
      refMem[5'(d + i)] = effFill ? fd : refMem[5'(s + i)];
  endtask

  // Drive one transfer. While it is busy, scramble the inputs and pulse
  // start once. Record the cycle of the done pulse, counting the start
  // cycle as cycle 0.
  task automatic applyStimulus(input logic [4:0] s, input logic [4:0] d,
                               input logic [5:0] l, input bit f,
                               input logic [31:0] fd, input int abortCyc,
                               input bit abortAtStart, output int doneCyc,
                               output bit abortedV, output bit cenSeen);
    bit gotDone;
    int cyc;
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len = l; fill = f; fill_data = fd;
    start = 1'b1; abort = abortAtStart; clearLog = 1'b1;
    gotDone = 1'b0; cyc = 0; doneCyc = -1; abortedV = 1'b0; cenSeen = 1'b0;
    while (!gotDone && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      clearLog  = 1'b0;
      start     = (cyc == 2);
      abort     = (cyc == abortCyc);
      src_addr  = 5'($urandom);
      dst_addr  = 5'($urandom);
      len       = 6'($urandom);
      fill      = 1'($urandom);
      fill_data = $urandom;
      if (M_cen === 1'b1) cenSeen = 1'b1;
      if (done === 1'b1) begin
        gotDone  = 1'b1;
        doneCyc  = cyc;
        abortedV = aborted;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic checkTransfer(input string name, input logic [4:0] s,
                               input logic [4:0] d, input logic [5:0] l,
                               input bit f, input logic [31:0] fd,
                               input int abortCyc, input bit abortAtStart,
                               input int expDone, input bit expAborted,
                               input int expWritten);
    int doneCyc;
    bit abortedV;
    bit cenSeen;
    bit effFill;
    effFill = f && FILL_EN;
    applyStimulus(s, d, l, f, fd, abortCyc, abortAtStart, doneCyc, abortedV, cenSeen);
    checkOutput({name, ".doneCycle"}, doneCyc, expDone);
    checkOutput({name, ".aborted"}, 32'(abortedV), 32'(expAborted));
    @(posedge clk); #1;
    checkOutput({name, ".donePulse"}, 32'(done), 32'd0);
    checkOutput({name, ".busyAfter"}, 32'(busy), 32'd0);
    if (l == 0) checkOutput({name, ".noAccess"}, 32'(cenSeen), 32'd0);
    checkOutput({name, ".reads"}, readLog.size(), effFill ? 0 : expWritten);
    for (int i = 0; i < readLog.size() && i < expWritten; i++)
      checkOutput($sformatf("%s.readAddr%0d", name, i), 32'(readLog[i]), 32'(5'(s + i)));
    checkOutput({name, ".writes"}, writeLog.size(), expWritten);
    for (int i = 0; i < writeLog.size() && i < expWritten; i++)
      checkOutput($sformatf("%s.writeAddr%0d", name, i), 32'(writeLog[i]), 32'(5'(d + i)));
    modelMove(s, d, expWritten, effFill, fd);
    checkMem(name);
  endtask

  typedef struct {
    string       name;
    logic [4:0]  src;
    logic [4:0]  dst;
    logic [5:0]  len;
    bit          fill;
    logic [31:0] fd;
    int          abortCyc;
    int          expDone;
    bit          expAborted;
    int          expWritten;
  } vec_t;

  vec_t vecs[8];

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    fill = 1'b0; fill_data = '0; abort = 1'b0; loadMem = 1'b1; clearLog = 1'b1;
    for (int i = 0; i < 32; i++) refMem[i] = initWord(i);

    vecs[0] = '{"copyBasic",  5'd1,  5'd8,  6'd4,  1'b0, 32'h0,        -1, 13, 1'b0, 4};
    vecs[1] = '{"copyWrap",   5'd30, 5'd2,  6'd4,  1'b0, 32'h0,        -1, 13, 1'b0, 4};
    vecs[2] = '{"zeroLen",    5'd3,  5'd9,  6'd0,  1'b0, 32'h0,        -1, 2,  1'b0, 0};
    vecs[3] = '{"abortRd2",   5'd10, 5'd20, 6'd5,  1'b0, 32'h0,        4,  7,  1'b1, 2};
    vecs[4] = '{"fillFull",   5'd0,  5'd0,  6'd32, 1'b1, 32'hA5A5A5A5, -1,
                FILL_EN ? 33 : 97, 1'b0, 32};
    vecs[5] = '{"abortWt1",   5'd12, 5'd14, 6'd3,  1'b0, 32'h0,        2,  4,  1'b1, 1};
    vecs[6] = '{"singleWord", 5'd31, 5'd0,  6'd1,  1'b0, 32'h0,        -1, 4,  1'b0, 1};
    vecs[7] = '{"fullWrap",   5'd0,  5'd16, 6'd32, 1'b0, 32'h0,        -1, 97, 1'b0, 32};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.M_cen",   32'(M_cen),   32'd0);
    checkOutput("reset.M_wen",   32'(M_wen),   32'd0);
    checkOutput("reset.M_addr",  32'(M_addr),  32'd0);
    checkOutput("reset.M_din",   M_din,        32'd0);
    checkOutput("reset.busy",    32'(busy),    32'd0);
    checkOutput("reset.done",    32'(done),    32'd0);
    checkOutput("reset.aborted", 32'(aborted), 32'd0);
    loadMem = 1'b0; clearLog = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    checkMem("preload");

    for (int v = 0; v < 8; v++)
      checkTransfer(vecs[v].name, vecs[v].src, vecs[v].dst, vecs[v].len,
                    vecs[v].fill, vecs[v].fd, vecs[v].abortCyc, 1'b0,
                    vecs[v].expDone, vecs[v].expAborted, vecs[v].expWritten);

    // Reset during the second word's WT. Only the first word has been
    // written, and no done pulse may follow.
    begin
      int doneSeen;
      @(posedge clk); #1;
      src_addr = 5'd0; dst_addr = 5'd16; len = 6'd6; fill = 1'b0; start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (c == 5) reset = 1'b1;
      end
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("midReset.M_cen", 32'(M_cen), 32'd0);
      checkOutput("midReset.busy",  32'(busy),  32'd0);
      checkOutput("midReset.done",  32'(done),  32'd0);
      doneSeen = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (done === 1'b1) doneSeen++;
      end
      checkOutput("midReset.noDone", doneSeen, 0);
      modelMove(5'd0, 5'd16, 1, 1'b0, 32'h0);
      checkMem("midReset");
      checkTransfer("afterReset", 5'd5, 5'd6, 6'd3, 1'b0, 32'h0, -1, 1'b0, 10, 1'b0, 3);
    end

    // Randomized transfers. Expected timing and word counts follow from
    // the per-word cycle cost and the abort rule.
    for (int t = 0; t < 25; t++) begin
      logic [4:0]  s, d;
      logic [5:0]  l;
      bit          f, eff, atStart;
      logic [31:0] fd;
      int          k, written, expDone, abortCyc;
      s  = 5'($urandom);
      d  = 5'($urandom);
      l  = 6'($urandom_range(0, 32));
      f  = 1'($urandom);
      fd = $urandom;
      eff = f && FILL_EN;
      k = 0;
      if (l > 1 && $urandom_range(0, 2) == 0) k = $urandom_range(1, int'(l) - 1);
      written  = (k > 0) ? k : int'(l);
      expDone  = (l == 0) ? 2 : (eff ? written + 1 : 3 * written + 1);
      abortCyc = (k == 0) ? -1 : (eff ? k : 3 * (k - 1) + 1 + $urandom_range(0, 2));
      atStart  = (k == 0) && ($urandom_range(0, 1) == 1);
      checkTransfer($sformatf("rand%0d", t), s, d, l, f, fd, abortCyc, atStart,
                    expDone, k > 0, written);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
